reset_sequencer: RTL and testbench



---
 rtl/reset_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_reset_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Source-side NoC reset sequencer: asserts every domain reset together, then releases the
// domains one at a time in index order behind synchronized acks. Macro RESET_SEQ_GAP_EN adds
// an idle gap between consecutive releases.
module reset_sequencer #(
    parameter int NUM_DOMAINS        = 4,
    parameter int MIN_ASSERT_CYCLES  = 16,
    parameter int ACK_TIMEOUT_CYCLES = 1024,
    parameter int ACK_SYNC_STAGES    = 2,
    parameter int GAP_CYCLES         = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   reset_req,
    output logic [NUM_DOMAINS-1:0] domain_reset_out,
    input  logic [NUM_DOMAINS-1:0] domain_reset_ack,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout_err
);

    localparam int MAX_AT  = (MIN_ASSERT_CYCLES > ACK_TIMEOUT_CYCLES) ? MIN_ASSERT_CYCLES : ACK_TIMEOUT_CYCLES;
    localparam int MAX_CNT = (GAP_CYCLES > MAX_AT) ? GAP_CYCLES : MAX_AT;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam int IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [CNT_W-1:0] ASSERT_LAST = CNT_W'(MIN_ASSERT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(ACK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_DOMAINS - 1);
`ifdef RESET_SEQ_GAP_EN
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE          = 3'd0,
        ST_ASSERT        = 3'd1,
        ST_WAIT_ACK_HIGH = 3'd2,
        ST_RELEASE       = 3'd3,
        ST_WAIT_ACK_LOW  = 3'd4,
        ST_FINISH        = 3'd5,
        ST_GAP           = 3'd6
    } state_t;

    state_t                 state_r, state_s;
    logic [CNT_W-1:0]       cnt_r, cnt_s, cnt_inc_s;
    logic [IDX_W-1:0]       idx_r, idx_s;
    logic                   timeout_hit_s;
    logic [NUM_DOMAINS-1:0] dro_r, dro_s;
    logic                   busy_r, busy_s;
    logic                   done_r, done_s;
    logic                   terr_r, terr_s;
    logic [NUM_DOMAINS-1:0] sync_r [ACK_SYNC_STAGES];
    logic [NUM_DOMAINS-1:0] ack_s;

    function automatic logic [NUM_DOMAINS-1:0] domain_bit(input logic [IDX_W-1:0] i);
        logic [NUM_DOMAINS-1:0] m;
        m = {NUM_DOMAINS{1'b0}};
        for (int d = 0; d < NUM_DOMAINS; d++) begin
            if (IDX_W'(d) == i) m[d] = 1'b1;
            else                m[d] = 1'b0;
        end
        return m;
    endfunction

    // Ack synchronizer chains; acks arrive from foreign clock domains
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ACK_SYNC_STAGES; i++) sync_r[i] <= {NUM_DOMAINS{1'b0}};
        end else begin
            sync_r[0] <= domain_reset_ack;
            for (int i = 1; i < ACK_SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
        end
    end

    assign ack_s     = sync_r[ACK_SYNC_STAGES-1];
    assign cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_W'(1);

    // State, counter, index and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_ASSERT;
            cnt_r   <= {CNT_W{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
            dro_r   <= {NUM_DOMAINS{1'b1}};
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            terr_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            idx_r   <= idx_s;
            dro_r   <= dro_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            terr_r  <= terr_s;
        end
    end

    // Next-state logic; a new request overrides every other transition
    always_comb begin
        state_s       = state_r;
        cnt_s         = cnt_inc_s;
        idx_s         = idx_r;
        timeout_hit_s = 1'b0;
        if (reset_req) begin
            state_s = ST_ASSERT;
            cnt_s   = {CNT_W{1'b0}};
            idx_s   = {IDX_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_s = {CNT_W{1'b0}};
                end
                ST_ASSERT: begin
                    if (cnt_r == ASSERT_LAST) begin
                        state_s = ST_WAIT_ACK_HIGH;
                        cnt_s   = {CNT_W{1'b0}};
                    end else begin
                        cnt_s   = cnt_inc_s;
                    end
                end
                ST_WAIT_ACK_HIGH: begin
                    if ((&ack_s) || (cnt_r == TO_LAST)) begin
                        timeout_hit_s = ~(&ack_s);
                        state_s       = ST_RELEASE;
                        cnt_s         = {CNT_W{1'b0}};
                        idx_s         = {IDX_W{1'b0}};
                    end else begin
                        cnt_s         = cnt_inc_s;
                    end
                end
                ST_RELEASE: begin
                    state_s = ST_WAIT_ACK_LOW;
                    cnt_s   = {CNT_W{1'b0}};
                end
                ST_WAIT_ACK_LOW: begin
                    if (!ack_s[idx_r] || (cnt_r == TO_LAST)) begin
                        timeout_hit_s = ack_s[idx_r];
                        cnt_s         = {CNT_W{1'b0}};
                        if (idx_r != IDX_LAST) begin
                            idx_s = idx_r + IDX_W'(1);
`ifdef RESET_SEQ_GAP_EN
                            state_s = ST_GAP;
`else
                            state_s = ST_RELEASE;
`endif
                        end else begin
                            state_s = ST_FINISH;
                        end
                    end else begin
                        cnt_s = cnt_inc_s;
                    end
                end
`ifdef RESET_SEQ_GAP_EN
                ST_GAP: begin
                    if (cnt_r == GAP_LAST) begin
                        state_s = ST_RELEASE;
                        cnt_s   = {CNT_W{1'b0}};
                    end else begin
                        cnt_s   = cnt_inc_s;
                    end
                end
`endif
                ST_FINISH: begin
                    state_s = ST_IDLE;
                    cnt_s   = {CNT_W{1'b0}};
                end
                default: begin
                    // Unreachable encodings fall back to a full reassert
                    state_s = ST_ASSERT;
                    cnt_s   = {CNT_W{1'b0}};
                    idx_s   = {IDX_W{1'b0}};
                end
            endcase
        end
    end

    // Next values of the registered outputs, derived from the transition being taken
    always_comb begin
        busy_s = (state_s != ST_IDLE);
        done_s = (state_s == ST_FINISH);
        if (state_s == ST_ASSERT) begin
            dro_s = {NUM_DOMAINS{1'b1}};
        end else if (state_s == ST_IDLE) begin
            dro_s = {NUM_DOMAINS{1'b0}};
        end else if (state_r == ST_RELEASE) begin
            dro_s = dro_r & ~domain_bit(idx_r);
        end else begin
            dro_s = dro_r;
        end
        if (reset_req) begin
            terr_s = 1'b0;
        end else if (timeout_hit_s) begin
            terr_s = 1'b1;
        end else begin
            terr_s = terr_r;
        end
    end

    assign domain_reset_out = dro_r;
    assign busy             = busy_r;
    assign done             = done_r;
    assign timeout_err      = terr_r;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios plus randomized requests/resets/stuck acks,
// checked every cycle against a phase-level behavioural model of the sequence.
module tb_reset_sequencer;

    localparam int ND   = 4;
    localparam int MINC = 16;
    localparam int TOC  = 64;
    localparam int SYNC = 2;
    localparam int GAPC = 8;
`ifdef RESET_SEQ_GAP_EN
    localparam int GAPX = GAPC;
`else
    localparam int GAPX = 0;
`endif
    localparam logic [ND-1:0] ALL = {ND{1'b1}};

    localparam int PH_IDLE = 0, PH_HOLD = 1, PH_WAIT_ALL = 2, PH_REL = 3;
    localparam int PH_WAIT_ONE = 4, PH_GAP = 5, PH_FIN = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          reset_req = 1'b0;
    logic [ND-1:0] domain_reset_ack = '0;
    logic [ND-1:0] domain_reset_out;
    logic          busy, done, timeout_err;

    reset_sequencer #(
        .NUM_DOMAINS(ND), .MIN_ASSERT_CYCLES(MINC), .ACK_TIMEOUT_CYCLES(TOC),
        .ACK_SYNC_STAGES(SYNC), .GAP_CYCLES(GAPC)
    ) dut (
        .clk(clk), .reset(reset), .reset_req(reset_req),
        .domain_reset_out(domain_reset_out), .domain_reset_ack(domain_reset_ack),
        .busy(busy), .done(done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Model: phase, cycles elapsed in phase, domain being handled, domains released so far
    int            ph = PH_HOLD, n = 0, k = 0, rel = 0;
    logic          m_terr = 1'b0;
    logic [ND-1:0] msync [SYNC];
    logic [ND-1:0] hist [4];
    logic [ND-1:0] stuck_hi = '0, stuck_lo = '0;
    int            cyc = 0;
    bit            chk_en = 1'b0;
    int            n_checks = 0, n_fail = 0;
    int            t_1110, t_1100, t_1000, t_0000, t_done, t_terr, done_cnt;

    function automatic logic [ND-1:0] exp_out();
        if (ph == PH_IDLE || ph == PH_FIN) return '0;
        return ALL << rel;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        logic [ND-1:0] acks;
        acks = msync[SYNC-1];
        for (int i = SYNC-1; i > 0; i--) msync[i] = msync[i-1];
        msync[0] = domain_reset_ack;
        if (reset) begin
            for (int i = 0; i < SYNC; i++) msync[i] = '0;
            ph = PH_HOLD; n = 0; k = 0; rel = 0; m_terr = 1'b0;
        end else if (reset_req) begin
            ph = PH_HOLD; n = 0; k = 0; rel = 0; m_terr = 1'b0;
        end else begin
            n++;
            case (ph)
                PH_HOLD: if (n == MINC) begin ph = PH_WAIT_ALL; n = 0; end
                PH_WAIT_ALL: if (acks == ALL || n == TOC) begin
                    if (acks != ALL) m_terr = 1'b1;
                    ph = PH_REL; k = 0; n = 0;
                end
                PH_REL: begin rel = k + 1; ph = PH_WAIT_ONE; n = 0; end
                PH_WAIT_ONE: if (!acks[k] || n == TOC) begin
                    if (acks[k]) m_terr = 1'b1;
                    n = 0;
                    if (k == ND-1) ph = PH_FIN;
                    else begin k++; ph = (GAPX > 0) ? PH_GAP : PH_REL; end
                end
                PH_GAP: if (n == GAPX) begin ph = PH_REL; n = 0; end
                PH_FIN: ph = PH_IDLE;
                default: ;
            endcase
        end
        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = exp_out();
    endtask

    task automatic clear_rec();
        t_1110 = -1; t_1100 = -1; t_1000 = -1; t_0000 = -1;
        t_done = -1; t_terr = -1; done_cnt = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        // Each domain echoes its reset request back three cycles later
        domain_reset_ack = (hist[3] | stuck_hi) & ~stuck_lo;
        chk_en = 1'b1;
        if (done === 1'b1) begin done_cnt++; t_done = cyc; end
        if (domain_reset_out === 4'b1110 && t_1110 < 0) t_1110 = cyc;
        if (domain_reset_out === 4'b1100 && t_1100 < 0) t_1100 = cyc;
        if (domain_reset_out === 4'b1000 && t_1000 < 0) t_1000 = cyc;
        if (domain_reset_out === 4'b0000 && busy === 1'b1 && t_0000 < 0) t_0000 = cyc;
        if (timeout_err === 1'b1 && t_terr < 0) t_terr = cyc;
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) tick();
    endtask

    task automatic pulse_req();
        reset_req = 1'b1;
        tick();
        reset_req = 1'b0;
    endtask

    task automatic wait_model_out(input logic [ND-1:0] val, input int budget, input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            if (exp_out() == val && ph != PH_IDLE) found = 1'b1;
            else tick();
        end
        check(name, 32'(found), 32'd1);
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("domain_reset_out", 32'(domain_reset_out), 32'(exp_out()));
            check("busy", 32'(busy), 32'(ph != PH_IDLE));
            check("done", 32'(done), 32'(ph == PH_FIN));
            check("timeout_err", 32'(timeout_err), 32'(m_terr));
        end
    end

    initial begin
        int q;
        for (int i = 0; i < SYNC; i++) msync[i] = '0;
        for (int i = 0; i < 4; i++) hist[i] = '0;
        clear_rec();

        // Power-on
        run(3);
        reset = 1'b0;
        run(60 + 3*GAPX);
        check("po_first_release", 32'(t_1110), 32'd21);
        check("po_second_release", 32'(t_1100), 32'(28 + GAPX));
        check("po_all_released", 32'(t_0000), 32'(42 + 3*GAPX));
        check("po_done_cycle", 32'(t_done), 32'(48 + 3*GAPX));
        check("po_done_count", 32'(done_cnt), 32'd1);
        check("po_busy_idle", 32'(busy), 32'd0);
        check("po_terr", 32'(timeout_err), 32'd0);

        // Idle re-request: identical timing relative to the request
        clear_rec();
        q = cyc;
        pulse_req();
        check("req_dro", 32'(domain_reset_out), 32'hF);
        check("req_busy", 32'(busy), 32'd1);
        run(60 + 3*GAPX);
        check("req_done_cycle", 32'(t_done), 32'(q + 46 + 3*GAPX));
        check("req_done_count", 32'(done_cnt), 32'd1);

        // Stuck ack on domain 2
        clear_rec();
        stuck_hi = 4'b0100;
        pulse_req();
        run(150 + 3*GAPX);
        check("stuck_timeout_delay", 32'(t_terr - t_1000), 32'd64);
        check("stuck_done_count", 32'(done_cnt), 32'd1);
        check("stuck_terr_idle", 32'(timeout_err), 32'd1);
        check("stuck_busy_idle", 32'(busy), 32'd0);
        stuck_hi = 4'b0000;

        // Mid-sequence request
        pulse_req();
        wait_model_out(4'b1100, 100, "mid_req_wait");
        q = cyc;
        pulse_req();
        clear_rec();
        check("mid_req_dro", 32'(domain_reset_out), 32'hF);
        check("mid_req_terr", 32'(timeout_err), 32'd0);
        run(60 + 3*GAPX);
        check("mid_req_hold", 32'(t_1110), 32'(q + 19));

        // Reset during the domain 1 ack wait
        pulse_req();
        wait_model_out(4'b1100, 100, "mid_rst_wait");
        q = cyc;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_rec();
        check("mid_rst_dro", 32'(domain_reset_out), 32'hF);
        check("mid_rst_busy", 32'(busy), 32'd1);
        check("mid_rst_done", 32'(done), 32'd0);
        run(60 + 3*GAPX);
        check("mid_rst_done_cycle", 32'(t_done), 32'(q + 46 + 3*GAPX));

        // Randomized requests, resets and stuck acks
        for (int c = 0; c < 3000; c++) begin
            if (c % 400 == 0) begin
                stuck_hi = ($urandom_range(0, 3) == 0) ? (4'b0001 << $urandom_range(0, ND-1)) : 4'b0000;
                stuck_lo = ($urandom_range(0, 3) == 0) ? (4'b0001 << $urandom_range(0, ND-1)) : 4'b0000;
            end
            reset_req = ($urandom_range(0, 299) == 0);
            reset     = ($urandom_range(0, 999) == 0);
            tick();
        end
        reset_req = 1'b0;
        reset = 1'b0;
        run(5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
